// File: rtl/complex_integrate_dump.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// complex_integrate_dump
//
// Integrate-and-dump stage placed after the complex multiplier. It sums
// ACC_LEN valid complex products, then presents the sum on a valid/ready
// output and starts a new window. Used for correlation and despreading.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   clear       synchronous restart of the integration window (acc, count,
//               overrun); the output register is left alone
//   din_valid   din_i/din_q carry a sample this cycle (no backpressure)
//   din_i       signed real part of the product        [DIN_WIDTH]
//   din_q       signed imaginary part of the product   [DIN_WIDTH]
//   dout_valid  dout_i/dout_q hold a completed sum
//   dout_ready  downstream accepts the sum this cycle
//   dout_i      signed real sum                        [ACC_WIDTH]
//   dout_q      signed imaginary sum                   [ACC_WIDTH]
//   sample_cnt  samples accumulated in current window  [CNT_WIDTH]
//   overrun     sticky: a completed sum was overwritten before acceptance
//
// Output state machine
//   state | meaning
//   EMPTY | no sum pending, dout_valid = 0
//   FULL  | sum held in dout_i/dout_q, dout_valid = 1
// ---------------------------------------------------------------------------
module complex_integrate_dump #(
  parameter  int DIN_WIDTH = 18,
  parameter  int ACC_LEN   = 16,
  localparam int CNT_WIDTH = $clog2(ACC_LEN),
  localparam int ACC_WIDTH = DIN_WIDTH + $clog2(ACC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 din_valid,
  input  logic [DIN_WIDTH-1:0] din_i,
  input  logic [DIN_WIDTH-1:0] din_q,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [ACC_WIDTH-1:0] dout_i,
  output logic [ACC_WIDTH-1:0] dout_q,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic                 overrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACC_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] dout_i_q, dout_i_d;
  logic [ACC_WIDTH-1:0] dout_q_q, dout_q_d;
  logic                 ovr_q, ovr_d;
  logic                 dump;

  logic [ACC_WIDTH-1:0] din_i_ext, din_q_ext;
  logic [ACC_WIDTH-1:0] sum_i, sum_q;

  // Sign-extend so the two's complement sum is exact at full width.
  assign din_i_ext = {{(ACC_WIDTH-DIN_WIDTH){din_i[DIN_WIDTH-1]}}, din_i};
  assign din_q_ext = {{(ACC_WIDTH-DIN_WIDTH){din_q[DIN_WIDTH-1]}}, din_q};
  assign sum_i     = acc_i_q + din_i_ext;
  assign sum_q     = acc_q_q + din_q_ext;

  // Accumulator, sample counter, output register and overrun flag.
  always_comb begin
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    cnt_d    = cnt_q;
    dout_i_d = dout_i_q;
    dout_q_d = dout_q_q;
    ovr_d    = ovr_q;
    dump     = 1'b0;

    if (clear) begin
      // clear wins over a same-cycle sample: it is dropped and cannot dump.
      acc_i_d = '0;
      acc_q_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (din_valid) begin
      if (cnt_q == CNT_LAST) begin
        dump     = 1'b1;
        dout_i_d = sum_i;
        dout_q_d = sum_q;
        acc_i_d  = '0;
        acc_q_d  = '0;
        cnt_d    = '0;
        // A pending sum is being replaced without having been taken.
        if ((state_q == FULL) && !dout_ready) begin
          ovr_d = 1'b1;
        end
      end else begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
        cnt_d   = cnt_q + CNT_ONE;
      end
    end
  end

  // Output handshake next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (dump) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (dout_ready && !dump) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      acc_i_q  <= '0;
      acc_q_q  <= '0;
      cnt_q    <= '0;
      dout_i_q <= '0;
      dout_q_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      cnt_q    <= cnt_d;
      dout_i_q <= dout_i_d;
      dout_q_q <= dout_q_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dout_valid = (state_q == FULL);
  assign dout_i     = dout_i_q;
  assign dout_q     = dout_q_q;
  assign sample_cnt = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_complex_integrate_dump.sv
`timescale 1ns/1ps
module tb_complex_integrate_dump;

  localparam int DW = 8;
  localparam int AL = 4;
  localparam int CW = 2;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          din_valid;
  logic [DW-1:0] din_i;
  logic [DW-1:0] din_q;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW-1:0] dout_i;
  logic [AW-1:0] dout_q;
  logic [CW-1:0] sample_cnt;
  logic          overrun;

  int passed = 0;
  int total  = 0;

  complex_integrate_dump #(.DIN_WIDTH(DW), .ACC_LEN(AL)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .din_valid  (din_valid),
    .din_i      (din_i),
    .din_q      (din_q),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_i     (dout_i),
    .dout_q     (dout_q),
    .sample_cnt (sample_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then sit 1 ns past it for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int vi, input int vq);
    din_valid = 1'b1;
    din_i     = DW'(vi);
    din_q     = DW'(vq);
    tick();
    din_valid = 1'b0;
    din_i     = '0;
    din_q     = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; din_valid = 1'b0; din_i = '0; din_q = '0; dout_ready = 1'b0;
    idle(2);
    total++; if (dout_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", dout_valid); else passed++;
    total++; if (dout_i !== AW'(0)) $display("FAIL reset_dout_i got %0d want 0", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(0)) $display("FAIL reset_dout_q got %0d want 0", $signed(dout_q)); else passed++;
    total++; if (sample_cnt !== CW'(0)) $display("FAIL reset_cnt got %0d want 0", sample_cnt); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %0b want 0", overrun); else passed++;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_dump();
    send(1, -1); send(2, -2); send(3, -3);
    total++; if (sample_cnt !== CW'(3)) $display("FAIL basic_cnt3 got %0d want 3", sample_cnt); else passed++;
    total++; if (dout_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", dout_valid); else passed++;
    send(4, -4);
    total++; if (dout_valid !== 1'b1) $display("FAIL basic_valid got %0b want 1", dout_valid); else passed++;
    total++; if (dout_i !== AW'(10)) $display("FAIL basic_dout_i got %0d want 10", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(-10)) $display("FAIL basic_dout_q got %0d want -10", $signed(dout_q)); else passed++;
    total++; if (sample_cnt !== CW'(0)) $display("FAIL basic_cnt0 got %0d want 0", sample_cnt); else passed++;
    idle(2);
    total++; if (dout_i !== AW'(10)) $display("FAIL basic_stable got %0d want 10", $signed(dout_i)); else passed++;
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL basic_accept got %0b want 0", dout_valid); else passed++;
  endtask

  task automatic test_extremes_gaps();
    send(-128, -128); idle(2);
    total++; if (sample_cnt !== CW'(1)) $display("FAIL gap_cnt1 got %0d want 1", sample_cnt); else passed++;
    send(-128, -128); idle(3);
    total++; if (sample_cnt !== CW'(2)) $display("FAIL gap_cnt2 got %0d want 2", sample_cnt); else passed++;
    send(-128, -128); idle(1);
    send(-128, -128);
    total++; if (dout_valid !== 1'b1) $display("FAIL ext_valid got %0b want 1", dout_valid); else passed++;
    total++; if (dout_i !== 10'h200) $display("FAIL ext_dout_i got %0d want -512", $signed(dout_i)); else passed++;
    total++; if (dout_q !== 10'h200) $display("FAIL ext_dout_q got %0d want -512", $signed(dout_q)); else passed++;
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
  endtask

  task automatic test_overrun();
    send(1, -1); send(2, -2); send(3, -3); send(4, -4);
    total++; if (overrun !== 1'b0) $display("FAIL ovr_first got %0b want 0", overrun); else passed++;
    send(5, -5); send(6, -6); send(7, -7); send(8, -8);
    total++; if (dout_i !== AW'(26)) $display("FAIL ovr_dout_i got %0d want 26", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(-26)) $display("FAIL ovr_dout_q got %0d want -26", $signed(dout_q)); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set got %0b want 1", overrun); else passed++;
    total++; if (dout_valid !== 1'b1) $display("FAIL ovr_valid got %0b want 1", dout_valid); else passed++;
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL ovr_drain got %0b want 0", dout_valid); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %0b want 1", overrun); else passed++;
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear got %0b want 0", overrun); else passed++;
  endtask

  task automatic test_simul_accept_dump();
    send(1, -1); send(2, -2); send(3, -3); send(4, -4);
    send(2, -2); send(2, -2); send(2, -2);
    dout_ready = 1'b1;
    send(2, -2);
    total++; if (dout_valid !== 1'b1) $display("FAIL sim_valid got %0b want 1", dout_valid); else passed++;
    total++; if (dout_i !== AW'(8)) $display("FAIL sim_dout_i got %0d want 8", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(-8)) $display("FAIL sim_dout_q got %0d want -8", $signed(dout_q)); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL sim_overrun got %0b want 0", overrun); else passed++;
    tick(); dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL sim_drain got %0b want 0", dout_valid); else passed++;
  endtask

  task automatic test_clear_mid_window();
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);
    send(1, -1); send(2, -2);
    total++; if (sample_cnt !== CW'(2)) $display("FAIL clr_pre_cnt got %0d want 2", sample_cnt); else passed++;
    clear = 1'b1;
    send(100, 100);
    clear = 1'b0;
    total++; if (sample_cnt !== CW'(0)) $display("FAIL clr_cnt got %0d want 0", sample_cnt); else passed++;
    total++; if (dout_valid !== 1'b1) $display("FAIL clr_pending_valid got %0b want 1", dout_valid); else passed++;
    total++; if (dout_i !== AW'(4)) $display("FAIL clr_pending_i got %0d want 4", $signed(dout_i)); else passed++;
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    total++; if (dout_valid !== 1'b0) $display("FAIL clr_drain got %0b want 0", dout_valid); else passed++;
    send(5, -5); send(5, -5); send(5, -5); send(5, -5);
    total++; if (dout_i !== AW'(20)) $display("FAIL clr_dout_i got %0d want 20", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(-20)) $display("FAIL clr_dout_q got %0d want -20", $signed(dout_q)); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL clr_overrun got %0b want 0", overrun); else passed++;
  endtask

  task automatic test_async_reset();
    // A sum of 20 is still pending from the previous test.
    send(1, 1); send(1, 1);
    total++; if (dout_valid !== 1'b1) $display("FAIL ar_pre_valid got %0b want 1", dout_valid); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (dout_valid !== 1'b0) $display("FAIL ar_valid got %0b want 0", dout_valid); else passed++;
    total++; if (dout_i !== AW'(0)) $display("FAIL ar_dout_i got %0d want 0", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(0)) $display("FAIL ar_dout_q got %0d want 0", $signed(dout_q)); else passed++;
    total++; if (sample_cnt !== CW'(0)) $display("FAIL ar_cnt got %0d want 0", sample_cnt); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL ar_overrun got %0b want 0", overrun); else passed++;
    #1 rst = 1'b0;
    tick();
    send(3, 7); send(3, 7); send(3, 7); send(3, 7);
    total++; if (dout_valid !== 1'b1) $display("FAIL ar_fresh_valid got %0b want 1", dout_valid); else passed++;
    total++; if (dout_i !== AW'(12)) $display("FAIL ar_fresh_i got %0d want 12", $signed(dout_i)); else passed++;
    total++; if (dout_q !== AW'(28)) $display("FAIL ar_fresh_q got %0d want 28", $signed(dout_q)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_extremes_gaps();
    test_overrun();
    test_simul_accept_dump();
    test_clear_mid_window();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
